// File: rtl/ebus_pkg.sv
// Shared EBUS definitions for the arbiter and its priority encoder.
//   EBUS_DATA_W  : default EBUS data width (bit 0 is the MSB, PDP-10 numbering)
//   tEBUSdriver  : one driver slot as produced by each EBUS source module
//   hold_state_e : hold watchdog states
//   owner_width  : owner-index width, max(1, clog2(n))
package ebus_pkg;

  localparam int unsigned EBUS_DATA_W = 36;

  // Per-module driver slot. The arbiter takes these flattened into separate
  // request and data vectors.
  typedef struct packed {
    logic                   driving;
    logic [0:EBUS_DATA_W-1] data;
  } tEBUSdriver;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StExpired
  } hold_state_e;

  function automatic int unsigned owner_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ebus_prio_enc.sv
// Fixed-priority encoder with a two-or-more detector.
//   req    : request vector, bit 0 has the highest priority
//   winner : index of the lowest set bit (0 when nothing is set)
//   any    : at least one request is set
//   multi  : two or more requests are set
module ebus_prio_enc
  import ebus_pkg::*;
#(
  parameter int unsigned N = 11,
  localparam int unsigned IW = owner_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] winner,
  output logic          any,
  output logic          multi
);

  // Scan downwards so the lowest set index is the one left standing.
  always_comb begin
    winner = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
  end

  assign any = |req;

  // Clearing the lowest set bit leaves something behind iff two or more are set.
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/ebus_arbiter.sv
// Registered EBUS arbiter with contention logging and a hold watchdog.
//   clk          : system clock
//   eboxReset    : asynchronous active-high reset
//   drvDriving   : per-source driving request (bit i = source i, 0 highest)
//   drvData      : per-source data, [N_DRV][0:DATA_W-1]
//   clrErr       : pulse clearing sticky error state and the contention counter
//   ebusData     : registered winning data (0 when nobody drove)
//   ebusValid    : some source drove in the previous cycle
//   owner        : registered winner index (holds when nobody drives)
//   contention   : sticky, two or more sources drove in one cycle
//   contMask     : drvDriving snapshot of the first contention since the last clear
//   contCount    : saturating count of contention cycles
//   holdTimeout  : sticky, one owner drove for HOLD_LIMIT consecutive cycles
//   timeoutOwner : owner captured when holdTimeout was set
module ebus_arbiter
  import ebus_pkg::*;
#(
  parameter int unsigned N_DRV      = 11,
  parameter int unsigned DATA_W     = EBUS_DATA_W,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned HOLD_LIMIT = 1024,
  localparam int unsigned OW_W      = owner_width(N_DRV)
) (
  input  logic                           clk,
  input  logic                           eboxReset,
  input  logic [N_DRV-1:0]               drvDriving,
  input  logic [N_DRV-1:0][0:DATA_W-1]   drvData,
  input  logic                           clrErr,
  output logic [0:DATA_W-1]              ebusData,
  output logic                           ebusValid,
  output logic [OW_W-1:0]                owner,
  output logic                           contention,
  output logic [N_DRV-1:0]               contMask,
  output logic [CNT_W-1:0]               contCount,
  output logic                           holdTimeout,
  output logic [OW_W-1:0]                timeoutOwner
);

  // Hold counter is just wide enough to hold HOLD_LIMIT, so it never wraps.
  localparam int unsigned     HC_W     = (HOLD_LIMIT == 0) ? 1 : $clog2(HOLD_LIMIT + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_LIMIT);

  logic [OW_W-1:0]   winner;
  logic              any;
  logic              multi;
  logic [0:DATA_W-1] sel_data;

  ebus_prio_enc #(
    .N (N_DRV)
  ) u_prio_enc (
    .req    (drvDriving),
    .winner (winner),
    .any    (any),
    .multi  (multi)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(N_DRV); i++) begin
      if (winner == OW_W'(i)) sel_data = drvData[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge eboxReset) begin
    if (eboxReset) begin
      ebusData  <= '0;
      ebusValid <= 1'b0;
      owner     <= '0;
    end else begin
      ebusData  <= any ? sel_data : '0;
      ebusValid <= any;
      if (any) owner <= winner;
    end
  end

  // ---------------------------------------------------------------------------
  // Contention logging
  // ---------------------------------------------------------------------------
  logic              first_q, first_d;
  logic              cont_d;
  logic [N_DRV-1:0]  mask_d;
  logic [CNT_W-1:0]  count_d;

  // The clear is applied first so that an event in the same cycle starts
  // from the cleared state: count becomes 1 and the mask is recaptured.
  always_comb begin
    cont_d  = contention;
    mask_d  = contMask;
    count_d = contCount;
    first_d = first_q;
    if (clrErr) begin
      cont_d  = 1'b0;
      mask_d  = '0;
      count_d = '0;
      first_d = 1'b0;
    end
    if (multi) begin
      cont_d = 1'b1;
      if (count_d != '1) count_d = count_d + CNT_W'(1);
      if (!first_d) begin
        mask_d  = drvDriving;
        first_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge eboxReset) begin
    if (eboxReset) begin
      contention <= 1'b0;
      contMask   <= '0;
      contCount  <= '0;
      first_q    <= 1'b0;
    end else begin
      contention <= cont_d;
      contMask   <= mask_d;
      contCount  <= count_d;
      first_q    <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold watchdog
  // ---------------------------------------------------------------------------
  hold_state_e     hold_state;
  logic [HC_W-1:0] hold_cnt;
  logic [HC_W-1:0] cnt_next;
  logic            same_owner;
  logic            frozen;
  logic            fire;

  // owner still holds last cycle's winner whenever the FSM is out of StIdle.
  assign same_owner = (winner == owner);
  assign frozen     = (hold_state == StExpired) && same_owner;

  // Count after this edge if the current winner keeps driving.
  always_comb begin
    cnt_next = HC_W'(1);
    if ((hold_state == StHold) && same_owner) cnt_next = hold_cnt + HC_W'(1);
  end

  assign fire = (HOLD_LIMIT != 0) && any && !frozen && (cnt_next == HOLD_MAX);

  always_ff @(posedge clk or posedge eboxReset) begin
    if (eboxReset) begin
      hold_state   <= StIdle;
      hold_cnt     <= '0;
      holdTimeout  <= 1'b0;
      timeoutOwner <= '0;
    end else begin
      if ((HOLD_LIMIT == 0) || !any) begin
        hold_state <= StIdle;
        hold_cnt   <= '0;
      end else if (fire) begin
        hold_state <= StExpired;
        hold_cnt   <= cnt_next;
      end else if (!frozen) begin
        hold_state <= StHold;
        hold_cnt   <= cnt_next;
      end

      // The first timeout since the last clear owns timeoutOwner.
      if (fire) begin
        holdTimeout <= 1'b1;
        if (!holdTimeout || clrErr) timeoutOwner <= winner;
      end else if (clrErr) begin
        holdTimeout  <= 1'b0;
        timeoutOwner <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ebus_arbiter.sv
module tb_ebus_arbiter;

  logic              clk;
  logic              rst;
  logic [10:0]       drv;
  logic [10:0][0:35] data;
  logic              clr;

  // Main instance: small counter, short watchdog.
  logic [0:35] ebus_data;
  logic        ebus_valid;
  logic [3:0]  owner;
  logic        cont;
  logic [10:0] cont_mask;
  logic [1:0]  cont_count;
  logic        hold_to;
  logic [3:0]  to_owner;

  // Watchdog disabled, default counter width.
  logic [0:35] dz_data;
  logic        dz_valid;
  logic [3:0]  dz_owner;
  logic        dz_cont;
  logic [10:0] dz_mask;
  logic [7:0]  dz_count;
  logic        dz_to;
  logic [3:0]  dz_towner;

  // Single-source instance.
  logic [0:35] d1_data;
  logic        d1_valid;
  logic [0:0]  d1_owner;
  logic        d1_cont;
  logic [0:0]  d1_mask;
  logic [7:0]  d1_count;
  logic        d1_to;
  logic [0:0]  d1_towner;

  ebus_arbiter #(.N_DRV(11), .DATA_W(36), .CNT_W(2), .HOLD_LIMIT(8)) u_dut (
    .clk          (clk),
    .eboxReset    (rst),
    .drvDriving   (drv),
    .drvData      (data),
    .clrErr       (clr),
    .ebusData     (ebus_data),
    .ebusValid    (ebus_valid),
    .owner        (owner),
    .contention   (cont),
    .contMask     (cont_mask),
    .contCount    (cont_count),
    .holdTimeout  (hold_to),
    .timeoutOwner (to_owner)
  );

  ebus_arbiter #(.N_DRV(11), .DATA_W(36), .CNT_W(8), .HOLD_LIMIT(0)) u_dz (
    .clk          (clk),
    .eboxReset    (rst),
    .drvDriving   (drv),
    .drvData      (data),
    .clrErr       (clr),
    .ebusData     (dz_data),
    .ebusValid    (dz_valid),
    .owner        (dz_owner),
    .contention   (dz_cont),
    .contMask     (dz_mask),
    .contCount    (dz_count),
    .holdTimeout  (dz_to),
    .timeoutOwner (dz_towner)
  );

  ebus_arbiter #(.N_DRV(1), .DATA_W(36), .CNT_W(8), .HOLD_LIMIT(8)) u_d1 (
    .clk          (clk),
    .eboxReset    (rst),
    .drvDriving   (drv[0]),
    .drvData      (data[0:0]),
    .clrErr       (clr),
    .ebusData     (d1_data),
    .ebusValid    (d1_valid),
    .owner        (d1_owner),
    .contention   (d1_cont),
    .contMask     (d1_mask),
    .contCount    (d1_count),
    .holdTimeout  (d1_to),
    .timeoutOwner (d1_towner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:35] data;
    logic        valid;
    logic [3:0]  owner;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_owner;
  int         checks;
  int         errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [10:0] m);
    for (int i = 0; i < 11; i++) begin
      if (m[i]) return i;
    end
    return -1;
  endfunction

  // Drive one cycle, predict the bus output, then compare it one edge later.
  task automatic step(input logic [10:0] mask, input logic clr_in);
    exp_t e;
    int   w;
    drv = mask;
    clr = clr_in;
    w   = lowest(mask);
    if (w >= 0) begin
      e.data    = data[w];
      e.valid   = 1'b1;
      e.owner   = 4'(w);
      exp_owner = 4'(w);
    end else begin
      e.data  = '0;
      e.valid = 1'b0;
      e.owner = exp_owner;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    clr = 1'b0;
    e = sb.pop_front();
    check("ebusData", 64'(ebus_data), 64'(e.data));
    check("ebusValid", 64'(ebus_valid), 64'(e.valid));
    check("owner", 64'(owner), 64'(e.owner));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ebusData"}, 64'(ebus_data), 64'd0);
    check({tag, ".ebusValid"}, 64'(ebus_valid), 64'd0);
    check({tag, ".owner"}, 64'(owner), 64'd0);
    check({tag, ".contention"}, 64'(cont), 64'd0);
    check({tag, ".contMask"}, 64'(cont_mask), 64'd0);
    check({tag, ".contCount"}, 64'(cont_count), 64'd0);
    check({tag, ".holdTimeout"}, 64'(hold_to), 64'd0);
    check({tag, ".timeoutOwner"}, 64'(to_owner), 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_owner = '0;
    rst       = 1'b1;
    clr       = 1'b0;
    drv       = '0;
    for (int i = 0; i < 11; i++) data[i] = 36'(i + 1) * 36'o001001001001;
    data[4] = 36'o123456701234;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single source
    step(11'h010, 1'b0);
    check("single.ebusData_octal", 64'(ebus_data), 64'(36'o123456701234));
    check("single.contention", 64'(cont), 64'd0);

    // Contention on {2,5} for three cycles
    for (int k = 0; k < 3; k++) step(11'h024, 1'b0);
    check("cont25.contention", 64'(cont), 64'd1);
    check("cont25.contMask", 64'(cont_mask), 64'h024);
    check("cont25.contCount", 64'(cont_count), 64'd3);
    check("cont25.dz_contCount", 64'(dz_count), 64'd3);

    // Further contention on {0,1}: mask keeps first snapshot, 2-bit count saturates
    for (int k = 0; k < 3; k++) step(11'h003, 1'b0);
    check("cont01.contMask", 64'(cont_mask), 64'h024);
    check("cont01.contCount_sat", 64'(cont_count), 64'd3);
    check("cont01.dz_contCount", 64'(dz_count), 64'd6);
    check("n1.owner", 64'(d1_owner), 64'd0);
    check("n1.contention", 64'(d1_cont), 64'd0);
    check("n1.ebusData", 64'(d1_data), 64'(data[0]));

    // Clear in the same cycle as new contention: event wins
    step(11'h480, 1'b1);
    check("clrcont.contention", 64'(cont), 64'd1);
    check("clrcont.contCount", 64'(cont_count), 64'd1);
    check("clrcont.contMask", 64'(cont_mask), 64'h480);
    check("clrcont.dz_contCount", 64'(dz_count), 64'd1);

    // Idle: data/valid drop, owner holds
    step(11'h000, 1'b0);
    step(11'h000, 1'b1);
    check("clr.contention", 64'(cont), 64'd0);
    check("clr.contMask", 64'(cont_mask), 64'd0);
    check("clr.contCount", 64'(cont_count), 64'd0);

    // Watchdog: source 7 for 20 cycles
    for (int k = 1; k <= 20; k++) begin
      step(11'h080, 1'b0);
      if (k == 7) check("wd7.before", 64'(hold_to), 64'd0);
      if (k == 8) begin
        check("wd7.at8", 64'(hold_to), 64'd1);
        check("wd7.timeoutOwner", 64'(to_owner), 64'd7);
      end
    end
    check("wd7.sticky", 64'(hold_to), 64'd1);
    // Source 3 times out too, owner capture stays 7
    for (int k = 0; k < 8; k++) step(11'h008, 1'b0);
    check("wd3.holdTimeout", 64'(hold_to), 64'd1);
    check("wd3.timeoutOwner", 64'(to_owner), 64'd7);
    step(11'h000, 1'b1);
    check("wdclr.holdTimeout", 64'(hold_to), 64'd0);
    check("wdclr.timeoutOwner", 64'(to_owner), 64'd0);

    // 7 + idle + 7 never reaches the limit
    for (int k = 0; k < 7; k++) step(11'h002, 1'b0);
    step(11'h000, 1'b0);
    for (int k = 0; k < 7; k++) step(11'h002, 1'b0);
    check("wdgap.holdTimeout", 64'(hold_to), 64'd0);
    step(11'h000, 1'b0);

    // Long hold: disabled watchdog never fires, main one captures owner 0
    for (int k = 0; k < 5000; k++) step(11'h001, 1'b0);
    check("wd0.dz_holdTimeout", 64'(dz_to), 64'd0);
    check("wd0.holdTimeout", 64'(hold_to), 64'd1);
    check("wd0.timeoutOwner", 64'(to_owner), 64'd0);
    step(11'h000, 1'b0);

    // Async reset mid-contention
    step(11'h006, 1'b0);
    step(11'h006, 1'b0);
    check("prerst.contention", 64'(cont), 64'd1);
    check("prerst.contMask", 64'(cont_mask), 64'h006);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("asyncrst");
    @(posedge clk);
    #1;
    check("inrst.ebusValid", 64'(ebus_valid), 64'd0);
    check("inrst.contention", 64'(cont), 64'd0);
    exp_owner = '0;
    drv = '0;
    @(negedge clk);
    rst = 1'b0;
    step(11'h020, 1'b0);
    check("postrst.contention", 64'(cont), 64'd0);
    check("postrst.contMask", 64'(cont_mask), 64'd0);
    check("postrst.holdTimeout", 64'(hold_to), 64'd0);
    step(11'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ebus_arbiter.md
Name: ebus_arbiter

Overview:
- Parametrised, registered successor to the fixed 11-source EBUS priority mux in the top level.
- Selects one of N_DRV EBUS drivers by fixed priority, with index 0 highest.
- Registers the winning data onto EBUS.
- Detects and logs multi-driver contention for diagnostics.
- Runs a hold watchdog that flags any source driving EBUS longer than allowed.
- Sits in the top level between the per-module EBUS driver structs (APR, CON, CRA, …, VMA, plus RH20/DTE20 slots) and the EBUS interface.

Parameters:
- N_DRV, 11: number of driver sources; legal range 1..32.
- DATA_W, 36: EBUS data width in bits (bit 0 is the MSB, PDP-10 numbering).
- CNT_W, 8: width of the saturating contention counter.
- HOLD_LIMIT, 1024: consecutive cycles one owner may drive before timeout; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- eboxReset  input  1  asynchronous, active-high reset.
- drvDriving  input  N_DRV  per-source driving request; bit i corresponds to source i.
- drvData  input  N_DRV x DATA_W  per-source data, packed as [N_DRV][0:DATA_W-1].
- clrErr  input  1  one-cycle pulse that clears sticky error state and the counter.
- ebusData  output  DATA_W  registered EBUS data.
- ebusValid  output  1  registered flag: some source drove EBUS in the previous cycle.
- owner  output  OW_W  registered index of the winning source; OW_W = max(1, clog2(N_DRV)).
- contention  output  1  sticky flag: two or more sources drove in the same cycle.
- contMask  output  N_DRV  drvDriving snapshot from the first contention since the last clear.
- contCount  output  CNT_W  saturating count of cycles with contention.
- holdTimeout  output  1  sticky watchdog flag.
- timeoutOwner  output  OW_W  owner index captured when holdTimeout was set.

Behaviour:
- Reset (async assert, release synchronous to clk): every output is 0, the hold counter is 0, and the internal "first captured" flag is clear.
- Selection is combinational over the current inputs; the winner is the lowest i with drvDriving[i] = 1.
- Latency is 1 cycle: on each clk edge, ebusData <= drvData[winner], owner <= winner, ebusValid <= 1.
- If no source is driving: ebusData <= 0, ebusValid <= 0, owner holds its previous value.
- Contention is popcount(drvDriving) >= 2. On each contention cycle:
  - contention <= 1.
  - contCount increments and saturates at all-ones, never wrapping.
  - contMask is loaded only if the first-captured flag is clear; that flag is then set.
- Hold watchdog states: IDLE, HOLD, EXPIRED.
  - IDLE: no driver. Moves to HOLD with cnt = 1 when ebusValid-to-be is 1.
  - HOLD: cnt increments while the same winner continues.
    - Winner changes: restart with cnt = 1 for the new winner.
    - No driver: back to IDLE with cnt = 0.
    - cnt reaches HOLD_LIMIT: holdTimeout <= 1, timeoutOwner <= winner, go to EXPIRED.
  - EXPIRED: counter frozen, and timeoutOwner is never overwritten. Leaves on winner change (HOLD, cnt = 1) or no driver (IDLE).
  - A later timeout while holdTimeout is still set does not update timeoutOwner.
  - HOLD_LIMIT = 0: the FSM stays in IDLE permanently and holdTimeout stays 0.
- The hold counter is wide enough to reach HOLD_LIMIT (clog2(HOLD_LIMIT + 1) bits) and never wraps.
- clrErr clears contention, contMask, contCount, holdTimeout, timeoutOwner and the first-captured flag.
  - It does not affect ebusData, ebusValid, owner or the watchdog FSM.
- clrErr in the same cycle as a new event: the new event wins. Flags set, contCount = 1, contMask captured fresh, timeoutOwner captured fresh.
- Reset asserted mid-hold or mid-contention: immediate return to reset values; no partial capture survives.
- N_DRV = 1: contention can never assert; owner is always 0.

Decomposition:
- Shared package ebus_pkg holds:
  - EBUS_DATA_W = 36.
  - the tEBUSdriver struct, parametrised by DATA_W.
  - a function for the owner-index width.
  - the hold-state enum (IDLE, HOLD, EXPIRED).
- One sub-module, ebus_prio_enc: parametrised priority encoder plus popcount-of-two detector. Outputs are winner index, any, and multi.
- The watchdog FSM and error logging stay in ebus_arbiter.

Test Plan:
- Only drvDriving[4] = 1 with data 36'o123456701234 -> next cycle ebusData = 36'o123456701234, owner = 4, ebusValid = 1, contention = 0.
- drvDriving = 11'b00000100100 (sources 2 and 5) for 3 cycles -> owner = 2, data from source 2, contention = 1, contMask = 0x024, contCount = 3. A later contention on {0,1} leaves contMask unchanged.
- CNT_W = 2 with 6 contention cycles -> contCount saturates at 3. clrErr in the same cycle as a further contention -> contention = 1, contCount = 1, contMask = new mask.
- HOLD_LIMIT = 8, source 7 driving 20 cycles -> holdTimeout rises on the 8th driven cycle, timeoutOwner = 7. Then source 3 drives for 8 cycles -> timeoutOwner stays 7.
- HOLD_LIMIT = 8, source 1 drives 7 cycles, idles 1 cycle, drives 7 more -> holdTimeout stays 0. HOLD_LIMIT = 0 with source 0 driving 5000 cycles -> holdTimeout stays 0.
- eboxReset pulsed asynchronously mid-contention, between clock edges -> all outputs drop to 0 immediately. After release, the first driven cycle gives ebusValid = 1 one clock later.
